// File: rtl/vmx_pkg.sv
// Shared types and constants for the vmx PE-array sequencer.
// Weight tag layout: bit 7 flags a weight word, bits 6:0 count down to the target PE.
package vmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_e;

    localparam int unsigned TAG_W             = 8;
    localparam int unsigned TAG_FLAG_BIT      = 7;
    localparam int unsigned TAG_CNT_W         = 7;
    localparam int unsigned VEC_LEN_W         = 16;
    localparam int unsigned DEF_N_PE          = 8;
    localparam int unsigned DEF_VECTOR_BITLEN = 16;

    function automatic logic [TAG_W-1:0] weight_tag(input logic [TAG_CNT_W-1:0] countdown);
        logic [TAG_W-1:0] tag;
        tag                  = '0;
        tag[TAG_FLAG_BIT]    = 1'b1;
        tag[TAG_CNT_W-1:0]   = countdown;
        return tag;
    endfunction

endpackage

// File: rtl/vmx_valid_pipe.sv
// Shift-register delay line carrying one valid bit per in-flight stream word.
module vmx_valid_pipe #(
    parameter int unsigned DEPTH = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o,
    output logic empty_o
);

    logic [DEPTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[DEPTH-1];
    assign empty_o = ~|stage_q;

endmodule

// File: rtl/vmx_seq_ctrl.sv
// Job sequencer for a chain of vmx PEs: loads weights, streams data, collects sums.
// Optional cycle counter output perf_cycles enabled by `define VMX_SEQ_PERF_CNT_EN.
module vmx_seq_ctrl
    import vmx_pkg::*;
#(
    parameter int unsigned N_PE           = DEF_N_PE,
    parameter int unsigned VECTOR_BITLEN  = DEF_VECTOR_BITLEN,
    parameter int unsigned PRODUCT_BITLEN = 2 * VECTOR_BITLEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      simd_cfg,
    input  logic [VEC_LEN_W-1:0]      vec_len,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    input  logic [VECTOR_BITLEN-1:0]  in_data,
    output logic                      in_ready,
    output logic                      arr_simd_mode,
    output logic [TAG_W-1:0]          arr_is_weight,
    output logic [VECTOR_BITLEN-1:0]  arr_data,
    output logic [PRODUCT_BITLEN-1:0] arr_sum_in,
    input  logic [PRODUCT_BITLEN-1:0] arr_sum_out,
    output logic                      res_valid,
    output logic [PRODUCT_BITLEN-1:0] res_data
`ifdef VMX_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam logic [TAG_CNT_W-1:0] LAST_IDX = TAG_CNT_W'(N_PE - 1);

    seq_state_e                  state_q, state_d;
    logic [TAG_CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [VEC_LEN_W-1:0]        rem_q, rem_d;
    logic                        simd_q, simd_d;
    logic [VECTOR_BITLEN-1:0]    arr_data_q, arr_data_d;
    logic [TAG_W-1:0]            tag_q, tag_d;
    logic                        done_q, done_d;
    logic                        res_valid_q, res_valid_d;
    logic [PRODUCT_BITLEN-1:0]   res_data_q, res_data_d;
    logic                        accept;
    logic                        stream_acc;
    logic                        pipe_out;
    logic                        pipe_empty;

    // Result valid leaves the pipe in the cycle the array presents that word's sum.
    vmx_valid_pipe #(
        .DEPTH (N_PE + 1)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (stream_acc),
        .valid_o (pipe_out),
        .empty_o (pipe_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            rem_q       <= '0;
            simd_q      <= 1'b0;
            arr_data_q  <= '0;
            tag_q       <= '0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rem_q       <= rem_d;
            simd_q      <= simd_d;
            arr_data_q  <= arr_data_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rem_d      = rem_q;
        simd_d     = simd_q;
        arr_data_d = '0;
        tag_d      = '0;
        done_d     = 1'b0;
        stream_acc = 1'b0;
        in_ready   = (state_q == ST_LOAD_W) || (state_q == ST_STREAM);
        accept     = in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    simd_d  = simd_cfg;
                    rem_d   = vec_len;
                    wcnt_d  = '0;
                    state_d = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    arr_data_d = in_data;
                    tag_d      = weight_tag(LAST_IDX - wcnt_q);
                    wcnt_d     = wcnt_q + TAG_CNT_W'(1);
                    if (wcnt_q == LAST_IDX) begin
                        state_d = (rem_q != '0) ? ST_STREAM : ST_DRAIN;
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    arr_data_d = in_data;
                    stream_acc = 1'b1;
                    rem_d      = rem_q - VEC_LEN_W'(1);
                    if (rem_q == VEC_LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        res_valid_d = pipe_out;
        res_data_d  = pipe_out ? arr_sum_out : res_data_q;
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign arr_simd_mode = busy & simd_q;
    assign arr_is_weight = tag_q;
    assign arr_data      = arr_data_q;
    assign arr_sum_in    = '0;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;

`ifdef VMX_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start) begin
            perf_d = '0;
        end else if (busy && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
